// File: rtl/mb_hsk_pkg.sv
// Shared types, limits and helpers for the mb_hsk_rx toggle-handshake receiver.
package mb_hsk_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } ch_state_t;

    localparam int NSYNC_MIN = 2;
    localparam int NSYNC_MAX = 4;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mb_hsk_rx_sync_chain.sv
// Single-bit NSYNC-deep synchroniser with synchronous active-high reset.
module sync_chain
    import mb_hsk_pkg::*;
#(
    parameter int NSYNC = NSYNC_MIN
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic [NSYNC-1:0] ff_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            ff_q <= '0;
        end else begin
            ff_q <= {ff_q[NSYNC-2:0], i_d};
        end
    end

    assign o_q = ff_q[NSYNC-1];

endmodule

// File: rtl/mb_hsk_rx.sv
// Destination side of a multi-channel toggle-handshake CDC: sync, capture, valid/ready, ack toggle.
// Optional per-channel accepted-transfer counters are enabled by defining MB_HSK_RX_STATS_EN.
module mb_hsk_rx
    import mb_hsk_pkg::*;
#(
    parameter int NB     = 8,
    parameter int NCH    = 2,
    parameter int NSYNC  = 2,
    parameter int NB_CNT = 16
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NCH-1:0]        i_req_tgl,
    input  logic [NCH*NB-1:0]     i_data,
    output logic [NCH*NB-1:0]     o_data,
    output logic [NCH-1:0]        o_valid,
    input  logic [NCH-1:0]        i_ready,
    output logic [NCH-1:0]        o_ack_tgl,
    output logic [NCH-1:0]        o_overrun,
    output logic                  o_init_done,
    output logic [NCH*NB_CNT-1:0] o_xfer_cnt
);

    localparam int            PW         = clog2(NSYNC + 1);
    localparam logic [PW-1:0] PRIME_LAST = PW'(NSYNC);
    localparam logic [PW-1:0] PRIME_ONE  = PW'(1);

    if (NSYNC < NSYNC_MIN || NSYNC > NSYNC_MAX) begin : g_bad_nsync
        $error("mb_hsk_rx: NSYNC out of range 2..4");
    end

    logic [PW-1:0] prime_q;
    logic          init_done_q;

    // Priming lets the edge-detect copies settle on whatever level the source already holds.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            prime_q     <= '0;
            init_done_q <= 1'b0;
        end else if (!init_done_q) begin
            if (prime_q == PRIME_LAST) begin
                init_done_q <= 1'b1;
            end else begin
                prime_q <= prime_q + PRIME_ONE;
            end
        end
    end

    assign o_init_done = init_done_q;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic            sync_out;
        logic            dly_q;
        logic            req_edge;
        logic            capture;
        logic            accept;
        logic            ovr_set;
        ch_state_t       state_q;
        ch_state_t       state_d;
        logic [NB-1:0]   data_q;
        logic            ack_q;
        logic            ovr_q;

        sync_chain #(
            .NSYNC (NSYNC)
        ) u_sync (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_d     (i_req_tgl[c]),
            .o_q     (sync_out)
        );

        assign req_edge = sync_out ^ dly_q;

        always_comb begin
            state_d = state_q;
            capture = 1'b0;
            accept  = 1'b0;
            ovr_set = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req_edge && init_done_q) begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // A new edge here means the source toggled before seeing ack.
                    ovr_set = req_edge;
                    if (i_ready[c]) begin
                        accept  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                state_q <= ST_IDLE;
                dly_q   <= 1'b0;
                data_q  <= '0;
                ack_q   <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dly_q   <= sync_out;
                if (capture) begin
                    data_q <= i_data[c*NB +: NB];
                end
                if (accept) begin
                    ack_q <= ~ack_q;
                end
                if (ovr_set) begin
                    ovr_q <= 1'b1;
                end
            end
        end

        assign o_data[c*NB +: NB] = data_q;
        assign o_valid[c]         = (state_q == ST_HOLD);
        assign o_ack_tgl[c]       = ack_q;
        assign o_overrun[c]       = ovr_q;

`ifdef MB_HSK_RX_STATS_EN
        localparam logic [NB_CNT-1:0] CNT_ONE = NB_CNT'(1);
        logic [NB_CNT-1:0] cnt_q;

        always_ff @(posedge i_clock) begin
            if (i_reset) begin
                cnt_q <= '0;
            end else if (accept) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end

        assign o_xfer_cnt[c*NB_CNT +: NB_CNT] = cnt_q;
`else
        assign o_xfer_cnt[c*NB_CNT +: NB_CNT] = '0;
`endif
    end

endmodule

// File: tb/tb_mb_hsk_rx.sv
// Directed plus randomized bench for mb_hsk_rx against a per-channel transaction model.
module tb_mb_hsk_rx;

    localparam int NB     = 8;
    localparam int NCH    = 2;
    localparam int NSYNC  = 2;
    localparam int NB_CNT = 4;

    logic                  i_clock = 1'b0;
    logic                  i_reset;
    logic [NCH-1:0]        i_req_tgl;
    logic [NCH*NB-1:0]     i_data;
    logic [NCH*NB-1:0]     o_data;
    logic [NCH-1:0]        o_valid;
    logic [NCH-1:0]        i_ready;
    logic [NCH-1:0]        o_ack_tgl;
    logic [NCH-1:0]        o_overrun;
    logic                  o_init_done;
    logic [NCH*NB_CNT-1:0] o_xfer_cnt;

    mb_hsk_rx #(
        .NB     (NB),
        .NCH    (NCH),
        .NSYNC  (NSYNC),
        .NB_CNT (NB_CNT)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_req_tgl   (i_req_tgl),
        .i_data      (i_data),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ack_tgl   (o_ack_tgl),
        .o_overrun   (o_overrun),
        .o_init_done (o_init_done),
        .o_xfer_cnt  (o_xfer_cnt)
    );

    always #5 i_clock = ~i_clock;

    // Reference model: what the downstream side should see, per channel.
    logic [NCH-1:0] m_valid, m_ack, m_ovr, src_tgl;
    logic [NB-1:0]  m_data [NCH];
    int             m_acc  [NCH];
    logic           m_init;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [NCH*NB-1:0] exp_data();
        logic [NCH*NB-1:0] v;
        v = '0;
        for (int c = 0; c < NCH; c++) v[c*NB +: NB] = m_data[c];
        return v;
    endfunction

    function automatic logic [NCH*NB_CNT-1:0] exp_cnt();
        logic [NCH*NB_CNT-1:0] v;
        v = '0;
`ifdef MB_HSK_RX_STATS_EN
        for (int c = 0; c < NCH; c++) v[c*NB_CNT +: NB_CNT] = NB_CNT'(m_acc[c] % (1 << NB_CNT));
`endif
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".valid"},   64'(o_valid),     64'(m_valid));
        check({tag, ".ack"},     64'(o_ack_tgl),   64'(m_ack));
        check({tag, ".overrun"}, 64'(o_overrun),   64'(m_ovr));
        check({tag, ".init"},    64'(o_init_done), 64'(m_init));
        check({tag, ".data"},    64'(o_data),      64'(exp_data()));
        check({tag, ".xfer"},    64'(o_xfer_cnt),  64'(exp_cnt()));
    endtask

    task automatic tick();
        @(posedge i_clock);
        #2;
    endtask

    task automatic model_reset();
        m_valid = '0;
        m_ack   = '0;
        m_ovr   = '0;
        m_init  = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            m_data[c] = '0;
            m_acc[c]  = 0;
        end
    endtask

    // Release reset and walk through priming: done NSYNC+1 edges later.
    task automatic release_and_prime();
        i_reset = 1'b0;
        for (int i = 1; i <= NSYNC + 1; i++) begin
            tick();
            if (i == NSYNC + 1) m_init = 1'b1;
            check_all("prime");
        end
    endtask

    task automatic toggle_req(input int c, input logic [NB-1:0] d);
        i_data[c*NB +: NB] = d;
        src_tgl[c] = ~src_tgl[c];
        i_req_tgl = src_tgl;
    endtask

    // Word becomes valid on the NSYNC+1-th edge counting the sampling edge.
    task automatic capture(input int c, input logic [NB-1:0] d);
        toggle_req(c, d);
        for (int i = 0; i < NSYNC; i++) begin
            tick();
            check_all("latency");
        end
        tick();
        m_valid[c] = 1'b1;
        m_data[c]  = d;
        check_all("capture");
    endtask

    task automatic accept(input int c, input int hold);
        for (int i = 0; i < hold; i++) begin
            tick();
            check_all("hold");
        end
        i_ready[c] = 1'b1;
        tick();
        m_valid[c] = 1'b0;
        m_ack[c]   = ~m_ack[c];
        m_acc[c]++;
        check_all("accept");
        i_ready[c] = 1'b0;
    endtask

    initial begin
        logic [NB-1:0] d;
        logic [NB_CNT-1:0] wrap_exp;

        // Reset with channel 0 source already high.
        i_reset   = 1'b1;
        src_tgl   = 2'b01;
        i_req_tgl = src_tgl;
        i_ready   = '0;
        i_data    = '0;
        model_reset();
        tick();
        tick();
        check_all("reset");
        release_and_prime();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all("post_prime");
        end

        // Channel 0 with ready already high: accept on the edge after capture.
        i_ready[0] = 1'b1;
        capture(0, 8'hA5);
        tick();
        m_valid[0] = 1'b0;
        m_ack[0]   = ~m_ack[0];
        m_acc[0]++;
        check_all("ch0_accept");
        check("ch0_ack_is_1", 64'(o_ack_tgl[0]), 64'd1);
        i_ready[0] = 1'b0;

        // Channel 1 back-pressured for 10 cycles.
        capture(1, 8'h3C);
        accept(1, 10);

        // Channel 1 second word, then a violating toggle before ack.
        capture(1, 8'($urandom));
        toggle_req(1, 8'($urandom));
        for (int i = 0; i < NSYNC; i++) begin
            tick();
            check_all("ovr_wait");
        end
        tick();
        m_ovr[1] = 1'b1;
        check_all("overrun");
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("overrun_sticky");
        end
        accept(1, 1);
        tick();
        check_all("overrun_after_accept");

        // Channel 0: illegal edge lands on the same edge as the accept.
        capture(0, 8'($urandom));
        toggle_req(0, 8'($urandom));
        for (int i = 0; i < NSYNC; i++) begin
            tick();
            check_all("simul_wait");
        end
        i_ready[0] = 1'b1;
        tick();
        m_valid[0] = 1'b0;
        m_ack[0]   = ~m_ack[0];
        m_acc[0]++;
        m_ovr[0]   = 1'b1;
        check_all("simul_accept_edge");
        i_ready[0] = 1'b0;
        tick();
        check_all("simul_settled");

        // Reset while channel 0 holds a word; source is reset alongside.
        capture(0, 8'($urandom));
        i_reset   = 1'b1;
        src_tgl   = '0;
        i_req_tgl = src_tgl;
        tick();
        model_reset();
        check_all("reset_in_hold");
        release_and_prime();

        // 17 randomized channel-0 transfers exercise the counter wrap; channel 1 interleaves.
        for (int n = 0; n < 17; n++) begin
            d = 8'($urandom);
            capture(0, d);
            accept(0, int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                capture(1, 8'($urandom));
                accept(1, int'($urandom_range(0, 2)));
            end
        end
`ifdef MB_HSK_RX_STATS_EN
        wrap_exp = NB_CNT'(17 % (1 << NB_CNT));
`else
        wrap_exp = '0;
`endif
        check("xfer_cnt_ch0_wrap", 64'(o_xfer_cnt[NB_CNT-1:0]), 64'(wrap_exp));
        check("no_overrun_after_rand", 64'(o_overrun), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
